// File: rtl/swi_conditioner.sv
// Slide-switch input conditioner: per-bit 2-flop synchronizer, stability-count debouncer,
// registered rise/fall/change strobes and a wrapping change counter.
module swi_conditioner #(
    parameter int unsigned NBITS         = 8,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned NBITS_CNT     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    input  logic [NBITS-1:0]     SWI,
    output logic [NBITS-1:0]     swi_db,
    output logic [NBITS-1:0]     swi_rise,
    output logic [NBITS-1:0]     swi_fall,
    output logic                 swi_changed,
    output logic [NBITS_CNT-1:0] change_cnt
);

    localparam int unsigned    CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [NBITS-1:0] accept;
    logic [CW-1:0]    cnt [NBITS];

    // A bit is accepted on the edge where it has differed for STABLE_CYCLES consecutive edges.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            accept[i] = (sync2[i] != swi_db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            swi_db      <= '0;
            swi_rise    <= '0;
            swi_fall    <= '0;
            swi_changed <= 1'b0;
            change_cnt  <= '0;
            for (int unsigned i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= SWI;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NBITS; i++) begin
                if (sync2[i] == swi_db[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            swi_db      <= swi_db ^ accept;
            swi_rise    <= accept & sync2;
            swi_fall    <= accept & ~sync2;
            swi_changed <= |accept;
            if (|accept) begin
                change_cnt <= change_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_swi_conditioner.sv
// Scoreboard bench for swi_conditioner: a window-based reference model pushes expected
// outputs per clock edge; a negedge monitor pops and compares.
module tb_swi_conditioner;

    localparam int unsigned SC = 3;

    logic       clk_2   = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] SWI     = 8'h00;
    logic [7:0] swi_db;
    logic [7:0] swi_rise;
    logic [7:0] swi_fall;
    logic       swi_changed;
    logic [7:0] change_cnt;

    typedef struct packed {
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
        logic [7:0] cnt;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    int   b7_pulses = 0;
    obs_t exp_q [$];

    // Reference model state: sync pipeline, window of past sync2 samples, accepted levels.
    logic [7:0] m_sync1 = '0;
    logic [7:0] m_sync2 = '0;
    logic [7:0] m_db    = '0;
    logic [7:0] m_cnt   = '0;
    logic [7:0] win [$];

    swi_conditioner #(.NBITS(8), .STABLE_CYCLES(SC), .NBITS_CNT(8)) dut (
        .clk_2       (clk_2),
        .reset_n     (reset_n),
        .SWI         (SWI),
        .swi_db      (swi_db),
        .swi_rise    (swi_rise),
        .swi_fall    (swi_fall),
        .swi_changed (swi_changed),
        .change_cnt  (change_cnt)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Model: a bit flips once its last SC sync2 samples all disagree with the accepted level.
    initial begin
        forever begin
            @(posedge clk_2 or negedge reset_n);
            if (!reset_n) begin
                m_sync1 = '0;
                m_sync2 = '0;
                m_db    = '0;
                m_cnt   = '0;
                win.delete();
                exp_q.delete();
            end else begin
                logic [7:0] acc;
                obs_t       e;
                win.push_back(m_sync2);
                if (win.size() > SC) void'(win.pop_front());
                acc = '0;
                if (win.size() == SC) begin
                    for (int unsigned b = 0; b < 8; b++) begin
                        logic all_diff;
                        all_diff = 1'b1;
                        foreach (win[k]) if (win[k][b] == m_db[b]) all_diff = 1'b0;
                        acc[b] = all_diff;
                    end
                end
                e.rise    = acc & ~m_db;
                e.fall    = acc & m_db;
                m_db      = m_db ^ acc;
                e.db      = m_db;
                e.changed = (acc != 8'h00);
                if (e.changed) m_cnt = m_cnt + 8'd1;
                e.cnt     = m_cnt;
                exp_q.push_back(e);
                m_sync2 = m_sync1;
                m_sync1 = SWI;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_2);
            if (!reset_n) begin
                checks++;
                if ({swi_db, swi_rise, swi_fall, swi_changed, change_cnt} !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs @%0t: got db=%h rise=%h fall=%h chg=%b cnt=%h, required all 0",
                             $time, swi_db, swi_rise, swi_fall, swi_changed, change_cnt);
                end
            end else if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = {swi_db, swi_rise, swi_fall, swi_changed, change_cnt};
                b7_pulses += int'(swi_rise[7]) + int'(swi_fall[7]);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got db=%h rise=%h fall=%h chg=%b cnt=%h, required db=%h rise=%h fall=%h chg=%b cnt=%h",
                             $time, a.db, a.rise, a.fall, a.changed, a.cnt,
                             e.db, e.rise, e.fall, e.changed, e.cnt);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] v, input int unsigned n);
        SWI = v;
        repeat (n) @(negedge clk_2);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] cnt_start;
        int         b7_start;

        // Held in reset with all switches high, then released with switches low.
        reset_n = 1'b0;
        SWI     = 8'hFF;
        repeat (3) @(negedge clk_2);
        SWI     = 8'h00;
        reset_n = 1'b1;
        drive(8'h00, 10);
        check_val("idle_cnt", 32'(change_cnt), 32'h0);

        // Single-bit rise.
        drive(8'h01, 8);
        check_val("rise_db", 32'(swi_db), 32'h01);
        check_val("rise_cnt", 32'(change_cnt), 32'h1);

        // Short glitch on bit 3 is rejected, then a 3-cycle high is accepted.
        drive(8'h09, 2);
        drive(8'h01, 6);
        check_val("glitch_db", 32'(swi_db), 32'h01);
        drive(8'h09, 3);
        drive(8'h01, 1);
        drive(8'h01, 8);

        // Multi-bit simultaneous change counts once.
        drive(8'h00, 8);
        drive(8'hC3, 8);
        check_val("multi_db", 32'(swi_db), 32'hC3);
        drive(8'h00, 8);
        check_val("multi_fall_db", 32'(swi_db), 32'h00);

        // Mid-count reset pulse: bit 2 counting, bit 0 accepted.
        drive(8'h01, 8);
        SWI = 8'h05;
        repeat (3) @(negedge clk_2);
        @(posedge clk_2);
        #1 reset_n = 1'b0;
        #1 check_val("async_reset", 32'({swi_db, swi_rise, swi_fall, swi_changed, change_cnt}), 32'h0);
        #2 reset_n = 1'b1;
        SWI = 8'h01;
        @(negedge clk_2);
        drive(8'h01, 10);
        check_val("post_reset_db", 32'(swi_db), 32'h01);

        // 256 full toggles of bit 7 wrap the change counter.
        drive(8'h00, 8);
        cnt_start = m_cnt;
        b7_start  = b7_pulses;
        v = 8'h00;
        for (int unsigned t = 0; t < 256; t++) begin
            v = v ^ 8'h80;
            drive(v, 6);
        end
        check_val("wrap_cnt", 32'(change_cnt), 32'(cnt_start));
        check_val("wrap_pulses", 32'(b7_pulses - b7_start), 32'd256);

        // Random per-bit flips: mix of glitches and stable runs.
        v = 8'h00;
        for (int unsigned t = 0; t < 2000; t++) begin
            logic [31:0] r;
            r = $urandom & $urandom & $urandom;
            v = v ^ r[7:0];
            drive(v, 1);
        end
        drive(v, 10);
        check_val("rand_final_db", 32'(swi_db), 32'(v));
        drive(8'h00, 10);
        check_val("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
